// File: rtl/shift_led_engine.sv
// shift_led_engine: WIDTH-bit LED pattern engine.
// The pattern advances on a prescaler tick (every DIV clocks while enable=1)
// or on a manual step, in one of four modes. wrap pulses for one cycle when a
// full pattern cycle completes.
//
// Build option: SHIFT_LED_STEP_SYNC_EN
//   defined   -> step goes through a 2-flop synchronizer plus rising-edge
//                detect, so one press (however long) gives one advance.
//   undefined -> step is used directly; every cycle with step=1 advances.
//
// mode | meaning
// -----+--------------------------------------------------------------
//  0   | ROTATE   : circular shift, wrap every WIDTH advances
//  1   | SHIFT    : zero-fill shift, reload INIT (and wrap) once empty
//  2   | PINGPONG : bounce between ends, wrap on each bounce
//  3   | JOHNSON  : twisted-ring counter, wrap every 2*WIDTH advances

module shift_led_engine #(
  parameter int               WIDTH = 8,
  parameter int               DIV   = 10_000_000,
  parameter logic [WIDTH-1:0] INIT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             dir_state,
  output logic             wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] ROT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] JOH_LAST = CW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    M_ROTATE   = 2'd0,
    M_SHIFT    = 2'd1,
    M_PINGPONG = 2'd2,
    M_JOHNSON  = 2'd3
  } mode_t;

  logic [PW-1:0]    presc;
  logic             tick;
  logic             step_evt;
  logic             adv;
  logic [1:0]       mode_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_base;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             ds_nxt;
  logic             wrap_nxt;
  logic             lead;
  logic             pp_dir;

  assign tick = enable && (presc == PRE_LAST);
  assign adv  = tick || step_evt;

  // Prescaler: counts 0..DIV-1 while enabled, restarts on disable or load
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc <= '0;
    else if (!enable || load || tick)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end

`ifdef SHIFT_LED_STEP_SYNC_EN
  logic [2:0] step_sr;

  // Step synchronizer (two flops) plus one history flop for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      step_sr <= '0;
    else
      step_sr <= {step_sr[1:0], step};
  end

  assign step_evt = step_sr[1] & ~step_sr[2];
`else
  assign step_evt = step;
`endif

  // Next pattern, direction, cycle count and wrap for this cycle
  always_comb begin
    cnt_base = (mode != mode_q) ? '0 : cnt;
    q_nxt    = q;
    ds_nxt   = dir_state;
    wrap_nxt = 1'b0;
    cnt_nxt  = cnt_base;
    lead     = 1'b0;
    pp_dir   = dir_state;
    if (load) begin
      q_nxt   = load_data;
      ds_nxt  = dir;
      cnt_nxt = '0;
    end else if (adv) begin
      case (mode_t'(mode))
        M_ROTATE: begin
          ds_nxt = dir;
          q_nxt  = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
          if (cnt_base == ROT_LAST) begin
            cnt_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_base + 1'b1;
          end
        end
        M_SHIFT: begin
          ds_nxt = dir;
          if (q == '0) begin
            q_nxt    = INIT;
            wrap_nxt = 1'b1;
          end else begin
            q_nxt = dir ? (q >> 1) : (q << 1);
          end
        end
        M_PINGPONG: begin
          // An empty pattern has nothing to bounce, so it simply holds
          if (q != '0) begin
            lead     = dir_state ? q[0] : q[WIDTH-1];
            pp_dir   = dir_state ^ lead;
            ds_nxt   = pp_dir;
            wrap_nxt = lead;
            q_nxt    = pp_dir ? (q >> 1) : (q << 1);
          end
        end
        default: begin
          ds_nxt = dir;
          q_nxt  = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
          if (cnt_base == JOH_LAST) begin
            cnt_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_base + 1'b1;
          end
        end
      endcase
    end
  end

  // Registered pattern state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= INIT;
      dir_state <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      mode_q    <= 2'd0;
    end else begin
      q         <= q_nxt;
      dir_state <= ds_nxt;
      wrap      <= wrap_nxt;
      cnt       <= cnt_nxt;
      mode_q    <= mode;
    end
  end

endmodule
